// File: rtl/mac_pipe_ctrl.sv
// Sequencing controller for the 5-stage FloatSD4 MAC pipeline: job FSM, shared stage hold and result FIFO.
// Optional build macro MAC_CTRL_PERF_EN adds saturating stall/bubble counters.
module mac_pipe_ctrl #(
   parameter int PIPE_DEPTH = 5,
   parameter int FIFO_DEPTH = 8,
   parameter int LEN_W      = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_job_len,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic             o_mac_valid,
   output logic             o_mac_inhibit,
   input  logic             i_mac_valid,
   input  logic [15:0]      i_mac_conv,
   output logic             o_out_valid,
   output logic [15:0]      o_out_data,
   input  logic             i_out_ready,
   output logic             o_busy,
   output logic             o_done
`ifdef MAC_CTRL_PERF_EN
   ,output logic [31:0]     o_stall_cnt
   ,output logic [31:0]     o_bubble_cnt
`endif
);

   localparam int DATA_W = 16;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int INF_W  = $clog2(PIPE_DEPTH + 1) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state, state_nxt;
   logic [LEN_W-1:0]  len, issued, retired;
   logic [INF_W-1:0]  inflight;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_nxt;
   logic [DATA_W-1:0] head_nxt;
   logic              out_valid_nxt;
   logic              fifo_full, push, pop, accept, start_ok, last_beat;

   function automatic logic [LEN_W-1:0] sat_retire(input logic [LEN_W-1:0] cur,
                                                   input logic [LEN_W-1:0] lim);
      return (cur == lim) ? cur : cur + LEN_W'(1);
   endfunction

   function automatic logic [INF_W-1:0] inflight_upd(input logic [INF_W-1:0] cur,
                                                     input logic inc, input logic dec);
      logic [INF_W-1:0] r;
      r = cur;
      if (inc && !dec)
         r = cur + INF_W'(1);
      else if (dec && !inc && cur != '0)
         r = cur - INF_W'(1);
      return r;
   endfunction

   // A stage-5 result may only advance if it can be written this cycle
   assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
   assign pop           = o_out_valid && i_out_ready;
   assign o_mac_inhibit = i_mac_valid && fifo_full && !pop;
   assign push          = i_mac_valid && !o_mac_inhibit;
   assign o_in_ready    = (state == RUN) && (issued < len) && !o_mac_inhibit;
   assign o_mac_valid   = i_in_valid && o_in_ready;
   assign accept        = o_mac_valid;
   assign start_ok      = (state == IDLE) && i_start;
   assign last_beat     = accept && ((issued + LEN_W'(1)) == len);

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CNT_W'(1);
      else if (pop && !push)
         count_nxt = count - CNT_W'(1);
   end

   // Head register: refilled from the bypass on an empty/one-deep FIFO, else from storage
   always_comb begin
      head_nxt      = o_out_data;
      out_valid_nxt = o_out_valid;
      if (count == '0) begin
         if (push) begin
            head_nxt      = i_mac_conv;
            out_valid_nxt = 1'b1;
         end
      end else if (pop) begin
         if (count == CNT_W'(1)) begin
            out_valid_nxt = push;
            if (push)
               head_nxt = i_mac_conv;
         end else begin
            head_nxt = mem[rd_ptr + PTR_W'(1)];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_start) state_nxt = (i_job_len == '0) ? DONE : RUN;
         RUN:     if (last_beat) state_nxt = DRAIN;
         DRAIN:   if ((retired == len) && (count_nxt == '0)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         len         <= '0;
         issued      <= '0;
         retired     <= '0;
         inflight    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         o_out_valid <= 1'b0;
         o_out_data  <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         state       <= state_nxt;
         o_busy      <= (state_nxt != IDLE);
         o_done      <= (state_nxt == DONE);
         count       <= count_nxt;
         o_out_valid <= out_valid_nxt;
         o_out_data  <= head_nxt;
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (start_ok) begin
            len      <= i_job_len;
            issued   <= '0;
            retired  <= '0;
            inflight <= '0;
         end else begin
            if (accept)
               issued <= issued + LEN_W'(1);
            if (push)
               retired <= sat_retire(retired, len);
            inflight <= inflight_upd(inflight, accept, push);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wr_ptr] <= i_mac_conv;
   end

`ifdef MAC_CTRL_PERF_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_stall_cnt  <= '0;
         o_bubble_cnt <= '0;
      end else if (start_ok) begin
         o_stall_cnt  <= '0;
         o_bubble_cnt <= '0;
      end else begin
         if (o_mac_inhibit)
            o_stall_cnt <= sat_inc32(o_stall_cnt);
         if ((state == RUN) && o_in_ready && !i_in_valid)
            o_bubble_cnt <= sat_inc32(o_bubble_cnt);
      end
   end
`endif

endmodule
